uart_tx_arbiter: RTL
====================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares one uart_tx instance between N_REQ byte requesters. Uses round-robin arbitration with packet lock.
//  Each requester may send multi-byte packets; the lock keeps a packet's bytes contiguous on the line.
//  Sequences uart_tx through its tx_vld/busy handshake, one byte per frame.
//  Owns baud_set, which changes only while the line is idle.
// PARAMETERS
//  N_REQ         4      number of requesters (2..8)
//  LOCK_TIMEOUT  65535  idle cycles a locked requester may stall before the lock is forcibly released (1..65535)
// PORTS
//  clk           in   1        system clock, single clock domain
//  rst_n         in   1        asynchronous active-low reset
//  req           in   N_REQ    per-requester byte request; hold until ack
//  req_data      in   8*N_REQ  byte for requester i in [8i+7:8i]; stable while req[i]=1
//  req_last      in   N_REQ    1 = this byte ends the packet (releases lock)
//  ack           out  N_REQ    1-cycle pulse: byte of requester i taken
//  baud_cfg      in   3        requested baud code (0..4, same coding as uart_tx)
//  baud_set      out  3        baud code driven to uart_tx
//  tx_din        out  8        byte to uart_tx
//  tx_vld        out  1        1-cycle send pulse to uart_tx
//  tx_busy       in   1        uart_tx busy (combinational tx_vld|tx_flag)
//  grant_id      out  3        index of current/last granted requester
//  active        out  1        1 from ISSUE until frame done
//  lock_timeout  out  1        1-cycle pulse when a lock is forcibly released
// BEHAVIOUR
//  Reset: all outputs 0 (ack, tx_vld, tx_din, baud_set, grant_id, active, lock_timeout); state IDLE; lock clear.
//   The round-robin pointer resets so requester 0 has top priority. rst_n mid-frame aborts immediately.
//   uart_tx shares rst_n.
//  All outputs are registered.
//  States: IDLE, ISSUE, WAIT_DONE, LOCK_WAIT.
//  IDLE:
//   - While tx_busy=0, baud_set<=baud_cfg every cycle; baud_set is frozen in all other states.
//   - If any req and tx_busy=0, select winner g: the first set req at or after (last_grant+1) mod N_REQ.
//   - Then tx_din<=req_data[g], grant_id<=g, lock<=~req_last[g], go to ISSUE.
//  ISSUE (exactly 1 cycle):
//   - tx_vld=1, ack[g]=1, active=1; go to WAIT_DONE.
//   - Latency is req seen at edge t -> tx_vld/ack high in cycle t+1.
//  WAIT_DONE:
//   - active=1. On tx_busy=0, go to LOCK_WAIT if lock, else IDLE with active=0.
//   - tx_busy stays 1 after ISSUE via uart_tx tx_flag, so no masking is needed.
//  LOCK_WAIT:
//   - Only requester g is served and others are ignored. lock_cnt is 16 bit and clears on entry.
//   - If req[g]: load tx_din/lock as in IDLE and go to ISSUE.
//   - Else lock_cnt++. When lock_cnt==LOCK_TIMEOUT-1: pulse lock_timeout, clear lock, go to IDLE.
//  last_grant updates to g only when a packet ends (req_last=1 sent or timeout). This gives packet-level fairness.
//  Simultaneous requests are resolved purely by the RR pointer.
//  A req that drops before ack is legal and is simply not served.
//  req_last is sampled with the byte; a requester dropping req mid-packet keeps the lock until timeout.
//  Back-to-back bytes leave at least 1 idle-line cycle between frames: busy low, then IDLE/LOCK_WAIT, then ISSUE.
//  A tx_busy=1 seen in IDLE (uart still active after reset) blocks issue until it falls.
//  baud_cfg values >4 are passed through; uart_tx defaults them to 115200.
// TESTING
//  Bench instantiates uart_tx (baud 0, 434 clk/bit) plus a line-side UART monitor.
//  1. req[2]=1, data 0xA5, last=1 -> ack[2] pulse the cycle after; line shows 0xA5 framed; active drops after ~4340 clk.
//  2. req=4'b1111, all last=1, held -> service order 0,1,2,3,0; exactly one ack per frame.
//  3. req[1] sends 3-byte packet (last on byte 3) while req[0],req[3] held -> bytes 1,1,1 contiguous, then 3, then 0.
//  4. req[2] sends last=0 then drops req; LOCK_TIMEOUT=16 -> lock_timeout pulse 16 cycles after frame done; next grant goes to a waiting requester.
//  5. Change baud_cfg 0->4 mid-frame -> baud_set stays 0 until frame ends, then 4; next frame is 52080 clk.
//  6. Assert rst_n low mid-frame -> all outputs 0 next cycle; after release, pending req[0] served first.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, packet-locked sharing of one uart_tx among N_REQ byte requesters
module uart_tx_arbiter #(
   parameter int N_REQ        = 4,
   parameter int LOCK_TIMEOUT = 65535
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N_REQ-1:0]   req,
   input  logic [8*N_REQ-1:0] req_data,
   input  logic [N_REQ-1:0]   req_last,
   output logic [N_REQ-1:0]   ack,
   input  logic [2:0]         baud_cfg,
   output logic [2:0]         baud_set,
   output logic [7:0]         tx_din,
   output logic               tx_vld,
   input  logic               tx_busy,
   output logic [2:0]         grant_id,
   output logic               active,
   output logic               lock_timeout
);
   localparam int IW = $clog2(N_REQ);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, LOCK_WAIT} state_t;
   state_t         state;
   logic           lock, any, issue;
   logic [IW-1:0]  g, last_grant, win, sel, idx;
   logic [15:0]    lock_cnt;
   always_comb begin
      win = '0;
      any = 1'b0;
      idx = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         idx = IW'((32'(last_grant) + 32'(i) + 32'd1) % N_REQ);
         if (req[idx]) begin
            win = idx;
            any = 1'b1;
         end
      end
   end
   assign sel      = (state == LOCK_WAIT) ? g : win;
   assign issue    = (state == IDLE && any && !tx_busy) || (state == LOCK_WAIT && req[g]);
   assign grant_id = 3'(g);
   // last_grant moves only on packet end, so a locked packet never loses its turn
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         lock         <= 1'b0;
         g            <= '0;
         last_grant   <= IW'(N_REQ - 1);
         lock_cnt     <= '0;
         ack          <= '0;
         baud_set     <= '0;
         tx_din       <= '0;
         tx_vld       <= 1'b0;
         active       <= 1'b0;
         lock_timeout <= 1'b0;
      end else begin
         ack          <= '0;
         tx_vld       <= 1'b0;
         lock_timeout <= 1'b0;
         if (issue) begin
            tx_din <= req_data[{sel, 3'b000} +: 8];
            g      <= sel;
            lock   <= ~req_last[sel];
            ack    <= N_REQ'(1) << sel;
            tx_vld <= 1'b1;
            active <= 1'b1;
            state  <= ISSUE;
            if (req_last[sel]) last_grant <= sel;
         end
         case (state)
            IDLE: if (!tx_busy) baud_set <= baud_cfg;
            ISSUE: state <= WAIT_DONE;
            WAIT_DONE: if (!tx_busy) begin
               active   <= 1'b0;
               lock_cnt <= '0;
               state    <= lock ? LOCK_WAIT : IDLE;
            end
            LOCK_WAIT: if (!issue) begin
               if (lock_cnt == 16'(LOCK_TIMEOUT - 1)) begin
                  lock_timeout <= 1'b1;
                  lock         <= 1'b0;
                  last_grant   <= g;
                  state        <= IDLE;
               end else begin
                  lock_cnt <= lock_cnt + 16'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
